// File: rtl/q16_coproc_alu.sv
`default_nettype none
// ============================================================================
// Module   : q16_coproc_alu
// Purpose  : Multi-cycle unsigned arithmetic engine on the module side of the
//            coprocessor bus. It takes a 24-bit command word on min/mstart and
//            returns a 24-bit result on mout with a one-cycle mrdy pulse. Every
//            accepted command produces exactly one mrdy pulse.
// Ports    : clk     - clock, rising edge
//            rst     - reset, asynchronous, active-high
//            mstart  - one-cycle command strobe
//            min     - command: [23:20] opcode, [19:16] reserved, [15:0] operand
//            mout    - registered result, valid while mrdy=1, held afterwards
//            mrdy    - result-valid pulse, one cycle per accepted command
//            busy    - high while MUL / DIV / SQRT iterate
// Config   : Q16CP_SQRT_EN - when defined, opcode 7 computes floor(sqrt(A))
//            in 8 iterations. When undefined, opcode 7 is an illegal command.
// Revision : 1.0 - initial release
// ============================================================================
module q16_coproc_alu #(
  parameter logic [23:0] ERR_CODE  = 24'h800000,
  parameter logic [15:0] DIV0_QUOT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mstart,
  input  logic [23:0] min,
  output logic [23:0] mout,
  output logic        mrdy,
  output logic        busy
);

  localparam logic [3:0] c_OP_LOADA  = 4'd1;
  localparam logic [3:0] c_OP_LOADB  = 4'd2;
  localparam logic [3:0] c_OP_MUL    = 4'd3;
  localparam logic [3:0] c_OP_GETHI  = 4'd4;
  localparam logic [3:0] c_OP_DIV    = 4'd5;
  localparam logic [3:0] c_OP_GETREM = 4'd6;
`ifdef Q16CP_SQRT_EN
  localparam logic [3:0] c_OP_SQRT   = 4'd7;
`endif
  localparam logic [3:0] c_LAST_ITER16 = 4'd15;
`ifdef Q16CP_SQRT_EN
  localparam logic [3:0] c_LAST_ITER8  = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
`ifdef Q16CP_SQRT_EN
    S_SQRT = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Architectural registers
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_r;       // remainder; also the partial remainder while iterating
  logic [31:0] r_p;       // exact product
  logic [23:0] r_mout;
  logic [3:0]  r_cnt;

  // Iteration working registers
  logic [31:0] r_mcand;   // MUL: A shifted left once per iteration
  logic [15:0] r_mplier;  // MUL: B shifted right; DIV/SQRT: dividend/radicand
                          // shifted left, quotient bits shifted in at the bottom

  // Command decode
  logic [3:0]  w_op;
  logic [15:0] w_operand;
  logic        w_accept;
  logic        w_b_zero;
  logic        w_unused_rsvd;

  assign w_op          = min[23:20];
  assign w_operand     = min[15:0];
  assign w_unused_rsvd = ^min[19:16];
  assign w_b_zero      = (r_b == 16'd0);
  // The DONE cycle behaves like IDLE for acceptance so commands can be
  // issued back-to-back in the same cycle as mrdy.
  assign w_accept      = mstart && ((r_state == S_IDLE) || (r_state == S_DONE));

  // MUL step: add the shifted multiplicand when the current multiplier bit is set
  logic [31:0] w_p_next;
  assign w_p_next = r_mplier[0] ? (r_p + r_mcand) : r_p;

  // DIV step (restoring). The partial remainder stays below B, so bit 16 of
  // the 17-bit difference is exactly the borrow: clear means "B fits".
  logic [16:0] w_div_sh;
  logic [16:0] w_div_sub;
  logic        w_div_ge;
  logic [15:0] w_div_rem;
  logic [15:0] w_div_quo;
  assign w_div_sh  = {r_r, r_mplier[15]};
  assign w_div_sub = w_div_sh - {1'b0, r_b};
  assign w_div_ge  = ~w_div_sub[16];
  assign w_div_rem = w_div_ge ? w_div_sub[15:0] : w_div_sh[15:0];
  assign w_div_quo = {r_mplier[14:0], w_div_ge};

`ifdef Q16CP_SQRT_EN
  // SQRT step (digit-by-digit, two radicand bits per iteration). The
  // remainder never exceeds 2*root, so it fits comfortably in 15 bits and the
  // top bit of the 17-bit difference again acts as the borrow.
  logic [7:0]  r_root;
  logic [16:0] w_sq_cur;
  logic [16:0] w_sq_trial;
  logic [16:0] w_sq_sub;
  logic        w_sq_ge;
  logic [15:0] w_sq_rem;
  logic [7:0]  w_sq_root;
  assign w_sq_cur   = {r_r[14:0], r_mplier[15:14]};
  assign w_sq_trial = {7'd0, r_root, 2'b01};
  assign w_sq_sub   = w_sq_cur - w_sq_trial;
  assign w_sq_ge    = ~w_sq_sub[16];
  assign w_sq_rem   = w_sq_ge ? w_sq_sub[15:0] : w_sq_cur[15:0];
  assign w_sq_root  = {r_root[6:0], w_sq_ge};
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    mrdy         = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        mrdy         = (r_state == S_DONE);
        w_state_next = S_IDLE;
        if (mstart) begin
          case (w_op)
            c_OP_MUL:  w_state_next = S_MUL;
            c_OP_DIV:  w_state_next = w_b_zero ? S_DONE : S_DIV;
`ifdef Q16CP_SQRT_EN
            c_OP_SQRT: w_state_next = S_SQRT;
`endif
            default:   w_state_next = S_DONE;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (r_cnt == c_LAST_ITER16) begin
          w_state_next = S_DONE;
        end
      end
`ifdef Q16CP_SQRT_EN
      S_SQRT: begin
        busy = 1'b1;
        if (r_cnt == c_LAST_ITER8) begin
          w_state_next = S_DONE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= 16'd0;
      r_b      <= 16'd0;
      r_r      <= 16'd0;
      r_p      <= 32'd0;
      r_mout   <= 24'd0;
      r_cnt    <= 4'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 16'd0;
`ifdef Q16CP_SQRT_EN
      r_root   <= 8'd0;
`endif
    end else if (w_accept) begin
      r_cnt <= 4'd0;
      case (w_op)
        c_OP_LOADA: begin
          r_a    <= w_operand;
          r_mout <= {8'h10, w_operand};
        end
        c_OP_LOADB: begin
          r_b    <= w_operand;
          r_mout <= {8'h20, w_operand};
        end
        c_OP_MUL: begin
          r_p      <= 32'd0;
          r_mcand  <= {16'd0, r_a};
          r_mplier <= r_b;
        end
        c_OP_GETHI: begin
          r_mout <= {16'h0000, r_p[31:24]};
        end
        c_OP_DIV: begin
          if (w_b_zero) begin
            r_r    <= r_a;
            r_mout <= {1'b1, 7'h00, DIV0_QUOT};
          end else begin
            r_r      <= 16'd0;
            r_mplier <= r_a;
          end
        end
        c_OP_GETREM: begin
          r_mout <= {8'h00, r_r};
        end
`ifdef Q16CP_SQRT_EN
        c_OP_SQRT: begin
          r_r      <= 16'd0;
          r_mplier <= r_a;
          r_root   <= 8'd0;
        end
`endif
        default: begin
          r_mout <= ERR_CODE;
        end
      endcase
    end else begin
      case (r_state)
        S_MUL: begin
          r_cnt    <= r_cnt + 4'd1;
          r_p      <= w_p_next;
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          if (r_cnt == c_LAST_ITER16) begin
            r_mout <= w_p_next[23:0];
          end
        end
        S_DIV: begin
          r_cnt    <= r_cnt + 4'd1;
          r_r      <= w_div_rem;
          r_mplier <= w_div_quo;
          if (r_cnt == c_LAST_ITER16) begin
            r_mout <= {8'h00, w_div_quo};
          end
        end
`ifdef Q16CP_SQRT_EN
        S_SQRT: begin
          r_cnt    <= r_cnt + 4'd1;
          r_r      <= w_sq_rem;
          r_root   <= w_sq_root;
          r_mplier <= {r_mplier[13:0], 2'b00};
          if (r_cnt == c_LAST_ITER8) begin
            r_mout <= {16'h0000, w_sq_root};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign mout = r_mout;

endmodule
`default_nettype wire

// File: tb/tb_q16_coproc_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_q16_coproc_alu
// Purpose  : Self-checking bench for q16_coproc_alu: a table of directed
//            command vectors, hand-written multi-cycle corner sequences, and
//            random commands checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_q16_coproc_alu;

`ifdef Q16CP_SQRT_EN
  localparam bit SQRT_ON = 1'b1;
`else
  localparam bit SQRT_ON = 1'b0;
`endif
  localparam logic [23:0] ERR = 24'h800000;

  logic        clk;
  logic        rst;
  logic        mstart;
  logic [23:0] min;
  logic [23:0] mout;
  logic        mrdy;
  logic        busy;

  int total;
  int bad;

  // Reference model state
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [15:0] m_r;
  logic [31:0] m_p;

  q16_coproc_alu dut (
    .clk    (clk),
    .rst    (rst),
    .mstart (mstart),
    .min    (min),
    .mout   (mout),
    .mrdy   (mrdy),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rsvd;
    logic [15:0] opnd;
    logic [23:0] exp_mout;
    logic [7:0]  exp_lat;
  } vec_t;

  vec_t vecs [0:20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: straight arithmetic on the architectural registers.
  task automatic model_step(input logic [3:0] op, input logic [15:0] d,
                            output logic [23:0] em, output int el);
    int s;
    em = ERR;
    el = 1;
    case (op)
      4'd1: begin m_a = d; em = {8'h10, d}; end
      4'd2: begin m_b = d; em = {8'h20, d}; end
      4'd3: begin m_p = {16'h0, m_a} * {16'h0, m_b}; em = m_p[23:0]; el = 17; end
      4'd4: em = {16'h0, m_p[31:24]};
      4'd5: begin
        if (m_b == 16'd0) begin
          m_r = m_a;
          em  = 24'h80FFFF;
        end else begin
          em  = {8'h00, 16'(m_a / m_b)};
          m_r = m_a % m_b;
          el  = 17;
        end
      end
      4'd6: em = {8'h00, m_r};
      4'd7: begin
`ifdef Q16CP_SQRT_EN
        s = 0;
        while ((s + 1) * (s + 1) <= int'(m_a)) s++;
        m_r = 16'(int'(m_a) - s * s);
        em  = {16'h0, 8'(s)};
        el  = 9;
`else
        s  = 0;
        em = ERR;
        el = 1 + s;
`endif
      end
      default: ;
    endcase
  endtask

  // Issue one command, measure latency (accept edge counts as 1), check the
  // result, that busy reflects an iterative op, and that mrdy is one cycle.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] rsvd,
                         input logic [15:0] opnd, input logic [23:0] exp_mout,
                         input int exp_lat, input string tag);
    int  lat;
    logic busy1;
    @(negedge clk);
    mstart = 1'b1;
    min    = {op, rsvd, opnd};
    @(posedge clk);
    #1;
    mstart = 1'b0;
    lat    = 1;
    busy1  = busy;
    while (!mrdy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_mout"}, {8'h0, mout}, {8'h0, exp_mout});
    chk({tag, "_busy"}, {31'd0, busy1}, {31'd0, (exp_lat > 1)});
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, mrdy}, 32'd0);
  endtask

  initial begin
    logic [23:0] em;
    int          el;
    logic [3:0]  op;
    logic [15:0] d;
    int          lat;
    int          pulses;
    logic        seen;

    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    mstart = 1'b0;
    min    = 24'd0;
    m_a = 16'd0; m_b = 16'd0; m_r = 16'd0; m_p = 32'd0;

    // Directed vectors
    vecs[0]  = '{4'h1, 4'h0, 16'h1234, 24'h101234, 8'd1};
    vecs[1]  = '{4'h2, 4'h0, 16'h0010, 24'h200010, 8'd1};
    vecs[2]  = '{4'h3, 4'h0, 16'h0000, 24'h012340, 8'd17};
    vecs[3]  = '{4'h4, 4'h0, 16'h0000, 24'h000000, 8'd1};
    vecs[4]  = '{4'h1, 4'h0, 16'hFFFF, 24'h10FFFF, 8'd1};
    vecs[5]  = '{4'h2, 4'h0, 16'hFFFF, 24'h20FFFF, 8'd1};
    vecs[6]  = '{4'h3, 4'h0, 16'h0000, 24'hFE0001, 8'd17};
    vecs[7]  = '{4'h4, 4'h0, 16'h0000, 24'h0000FF, 8'd1};
    vecs[8]  = '{4'h1, 4'h0, 16'd100,  24'h100064, 8'd1};
    vecs[9]  = '{4'h2, 4'h0, 16'd7,    24'h200007, 8'd1};
    vecs[10] = '{4'h5, 4'h0, 16'h0000, 24'h00000E, 8'd17};
    vecs[11] = '{4'h6, 4'h0, 16'h0000, 24'h000002, 8'd1};
    vecs[12] = '{4'h2, 4'h0, 16'h0000, 24'h200000, 8'd1};
    vecs[13] = '{4'h5, 4'h0, 16'h0000, 24'h80FFFF, 8'd1};
    vecs[14] = '{4'h6, 4'h0, 16'h0000, 24'h000064, 8'd1};
    vecs[15] = '{4'h1, 4'h0, 16'd200,  24'h1000C8, 8'd1};
    vecs[16] = '{4'h7, 4'h0, 16'h0000, SQRT_ON ? 24'h00000E : ERR, SQRT_ON ? 8'd9 : 8'd1};
    vecs[17] = '{4'h6, 4'h0, 16'h0000, SQRT_ON ? 24'h000004 : 24'h000064, 8'd1};
    vecs[18] = '{4'hF, 4'h0, 16'h0000, ERR, 8'd1};
    vecs[19] = '{4'h0, 4'hA, 16'h5555, ERR, 8'd1};
    vecs[20] = '{4'h1, 4'hF, 16'hABCD, 24'h10ABCD, 8'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mout", {8'h0, mout}, 32'd0);
    chk("rst_mrdy", {31'd0, mrdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a multiply aborts it
    run_cmd(4'h1, 4'h0, 16'd3, 24'h100003, 1, "rm_loada");
    run_cmd(4'h2, 4'h0, 16'd5, 24'h200005, 1, "rm_loadb");
    @(negedge clk);
    mstart = 1'b1;
    min    = {4'h3, 20'h0};
    @(posedge clk);
    #1;
    mstart = 1'b0;
    seen   = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (mrdy) seen = 1'b1;
    end
    chk("rm_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rm_mout", {8'h0, mout}, 32'd0);
    chk("rm_mrdy", {31'd0, mrdy}, 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (mrdy) seen = 1'b1;
    end
    chk("rm_no_mrdy", {31'd0, seen}, 32'd0);
    m_a = 16'd0; m_b = 16'd0; m_r = 16'd0; m_p = 32'd0;
    run_cmd(4'h4, 4'h0, 16'h0, 24'h000000, 1, "rm_gethi");

    // Table-driven directed vectors
    for (int i = 0; i <= 20; i++) begin
      model_step(vecs[i].op, vecs[i].opnd, em, el);
      run_cmd(vecs[i].op, vecs[i].rsvd, vecs[i].opnd, vecs[i].exp_mout,
              int'(vecs[i].exp_lat), $sformatf("vec%0d", i));
    end

    // Command during MUL is dropped; command in the mrdy cycle is accepted
    run_cmd(4'h1, 4'h0, 16'd3, 24'h100003, 1, "dr_loada");
    run_cmd(4'h2, 4'h0, 16'd5, 24'h200005, 1, "dr_loadb");
    @(negedge clk);
    mstart = 1'b1;
    min    = {4'h3, 20'h0};
    @(posedge clk);
    #1;
    mstart = 1'b0;
    lat    = 1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat++;
      if (mrdy) pulses++;
    end
    mstart = 1'b1;
    min    = {4'h1, 4'h0, 16'h00FF};
    @(posedge clk);
    #1;
    mstart = 1'b0;
    lat++;
    if (mrdy) pulses++;
    while (!mrdy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("dr_lat", lat, 17);
    chk("dr_mout", {8'h0, mout}, 32'h00000F);
    chk("dr_early_pulses", pulses, 0);
    mstart = 1'b1;
    min    = {4'h3, 20'h0};
    @(posedge clk);
    #1;
    mstart = 1'b0;
    lat    = 1;
    chk("b2b_mrdy_drop", {31'd0, mrdy}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    while (!mrdy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_lat", lat, 17);
    chk("b2b_mout", {8'h0, mout}, 32'h00000F);
    @(posedge clk);
    #1;
    chk("b2b_pulse", {31'd0, mrdy}, 32'd0);
    m_a = 16'd3; m_b = 16'd5; m_p = 32'd15;

    // Random commands against the model
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 7));
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d = 16'd0;
      model_step(op, d, em, el);
      run_cmd(op, 4'($urandom), d, em, el, $sformatf("rnd%0d_op%0h", i, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
